// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//   In-order write buffer between the WB stage and the register file's single
//   write port. Requests are queued in a DEPTH-entry FIFO and drained one per
//   cycle. While entries are pending, both read ports get youngest-match bypass
//   data so decode never sees a stale register value.
// Ports:
//   clk, reset (sync, active-high)
//   wb_valid/wb_ready/wb_sel/wb_data       : writeback request handshake
//   rf_busy                                : write port owned by preload path
//   rf_writenable/rf_writesel/rf_din       : to the register file write port
//   rs1_sel/rs2_sel                        : read selects (same as to the RF)
//   rs1_hit/rs1_data, rs2_hit/rs2_data     : bypass result per read port
//   count                                  : occupied entries

// One bypass search port: youngest occupied entry whose select matches.
module rfwb_bypass #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int PTR_W  = 2
) (
  input  logic [PTR_W-1:0]              rd_ptr,
  input  logic [DEPTH-1:0]              vld,
  input  logic [DEPTH-1:0][SEL_W-1:0]   sel,
  input  logic [DEPTH-1:0][DATA_W-1:0]  data,
  input  logic [SEL_W-1:0]              rs_sel,
  output logic                          hit,
  output logic [DATA_W-1:0]             rs_data
);
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    hit     = 1'b0;
    rs_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((rs_sel != '0) && vld[idx] && (sel[idx] == rs_sel)) begin
        hit     = 1'b1;
        rs_data = data[idx];
      end
    end
  end
endmodule

module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [SEL_W-1:0]           wb_sel,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rf_busy,
  output logic                       rf_writenable,
  output logic [SEL_W-1:0]           rf_writesel,
  output logic [DATA_W-1:0]          rf_din,
  input  logic [SEL_W-1:0]           rs1_sel,
  input  logic [SEL_W-1:0]           rs2_sel,
  output logic                       rs1_hit,
  output logic                       rs2_hit,
  output logic [DATA_W-1:0]          rs1_data,
  output logic [DATA_W-1:0]          rs2_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NPORTS = 2;

  logic [DEPTH-1:0][SEL_W-1:0]  sel_q,  sel_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q,  count_d;

  logic push, pop, nonempty;

  // Ready looks only at registered occupancy, so a same-cycle pop never
  // frees a slot for the current request.
  assign wb_ready      = (count_q != CNT_W'(DEPTH));
  assign nonempty      = (count_q != '0);
  assign rf_writenable = nonempty && !rf_busy;
  assign rf_writesel   = nonempty ? sel_q[rd_ptr_q]  : '0;
  assign rf_din        = nonempty ? data_q[rd_ptr_q] : '0;
  assign count         = count_q;

  // r0 writes are consumed by the handshake but never stored.
  assign push = wb_valid && wb_ready && (wb_sel != '0);
  assign pop  = rf_writenable;

  always_comb begin
    sel_d    = sel_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // push and pop never target the same slot: a push needs a free slot and
    // a pop needs an occupied one, and wr==rd only when empty or full.
    if (push) begin
      sel_d[wr_ptr_q]  = wb_sel;
      data_d[wr_ptr_q] = wb_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= '0;
      data_q   <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sel_q    <= sel_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bypass search, one instance per read port.
  logic [NPORTS-1:0][SEL_W-1:0]  rs_sel_v;
  logic [NPORTS-1:0]             rs_hit_v;
  logic [NPORTS-1:0][DATA_W-1:0] rs_data_v;

  assign rs_sel_v[0] = rs1_sel;
  assign rs_sel_v[1] = rs2_sel;

  for (genvar g = 0; g < NPORTS; g++) begin : g_byp
    rfwb_bypass #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W), .PTR_W(PTR_W)
    ) u_byp (
      .rd_ptr  (rd_ptr_q),
      .vld     (vld_q),
      .sel     (sel_q),
      .data    (data_q),
      .rs_sel  (rs_sel_v[g]),
      .hit     (rs_hit_v[g]),
      .rs_data (rs_data_v[g])
    );
  end

  assign rs1_hit  = rs_hit_v[0];
  assign rs2_hit  = rs_hit_v[1];
  assign rs1_data = rs_data_v[0];
  assign rs2_data = rs_data_v[1];
endmodule
